// File: rtl/cla_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_serial_adder
//
// Purpose:
//   Multi-cycle wide adder. Each clock it adds one DIGIT-bit slice of two
//   WIDTH-bit operands using 4-bit style carry lookahead, and feeds the
//   registered slice carry-out into the next slice's carry-in. After the
//   last slice the full sum, carry-out and signed overflow are presented
//   until the consumer takes them.
//
// Parameters:
//   WIDTH      operand/sum width in bits, a multiple of DIGIT
//   DIGIT      bits added per cycle (slice width), at least 2
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand set a/b/cin is valid
//   in_ready   out  1      operands accepted (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry into bit 0
//   out_valid  out  1      sum/cout/ovf valid (high only in DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  a + b + cin modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow
//   busy       out  1      high in RUN or DONE
// ---------------------------------------------------------------------------
module cla_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT-1:0]   slice_p;
  logic [DIGIT-1:0]   slice_g;
  logic [DIGIT:0]     carries;
  logic [DIGIT-1:0]   slice_sum;
  logic               last_slice;

  assign last_slice = (k_q == KW'(NSLICE - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshake flags decode straight from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Lookahead carry chain for the slice currently at the bottom of the
  // operand shift registers. The chain seed is the registered carry from
  // the previous slice (or cin for slice 0).
  always_comb begin
    slice_p    = a_q[DIGIT-1:0] ^ b_q[DIGIT-1:0];
    slice_g    = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
    carries    = '0;
    carries[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      carries[i+1] = slice_g[i] | (slice_p[i] & carries[i]);
    end
    slice_sum = slice_p ^ carries[DIGIT-1:0];
  end

  // Datapath next state. Rather than indexing slice k with a variable
  // part-select, the latched operands shift down by DIGIT every RUN cycle
  // and each new sum slice enters at the top of the sum register. After
  // NSLICE cycles slice k has landed in bits k*DIGIT+DIGIT-1 .. k*DIGIT.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = carries[DIGIT];
        k_d     = k_q + KW'(1);
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
        if (last_slice) begin
          cout_d = carries[DIGIT];
          // The top slice's carry into its MSB is carries[DIGIT-1].
          ovf_d  = carries[DIGIT-1] ^ carries[DIGIT];
        end
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_serial_adder
//
// Purpose:
//   Self-checking bench for cla_serial_adder (WIDTH=16, DIGIT=4). A table of
//   hand-computed vectors is run through the full handshake, followed by
//   hand-written sequences for backpressure, ignored input during RUN,
//   reset in the middle of an add, and back-to-back random adds checked
//   against a small arithmetic model.
// ---------------------------------------------------------------------------
module tb_cla_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] expSum;
    logic        expCout;
    logic        expOvf;
  } vec_t;

  vec_t vecs[8];

  cla_serial_adder #(
    .WIDTH(16),
    .DIGIT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a DUT that never reaches the summary on its own.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full add: wait for in_ready, present operands for one accept edge,
  // scramble the inputs, measure latency, check the result, stall for
  // 'stall' cycles with out_ready low, then hand the result off.
  task automatic applyStimulus(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                               input logic tc, input logic [15:0] es, input logic ec,
                               input logic eo, input int stall);
    int waitCnt;
    int lat;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = ~ta;
    b        = ~tb;
    cin      = ~tc;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd4);
    checkOutput({tag, " sum"}, 32'(sum), 32'(es));
    checkOutput({tag, " cout"}, 32'(cout), 32'(ec));
    checkOutput({tag, " ovf"}, 32'(ovf), 32'(eo));
    checkOutput({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      checkOutput({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " stall sum"}, 32'(sum), 32'(es));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " sum held in IDLE"}, 32'(sum), 32'(es));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] full;
    logic        expOvf;
    int          lat;
    int          stall;
    logic        sawValid;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    cin       = 1'b0;
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf, 0);
    end

    // New operands pulsed during RUN and DONE must be ignored, and the
    // result must stay put while out_ready is held low.
    a        = 16'h1234;
    b        = 16'h4321;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("ignore busy in RUN", 32'(busy), 32'd1);
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b1;
    in_valid = 1'b1;
    checkOutput("ignore in_ready in RUN", 32'(in_ready), 32'd0);
    tick();
    tick();
    lat = 3;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("ignore latency", 32'(lat), 32'd4);
    for (int s = 0; s < 5; s++) begin
      checkOutput("backpressure out_valid", 32'(out_valid), 32'd1);
      checkOutput("backpressure in_ready", 32'(in_ready), 32'd0);
      checkOutput("backpressure sum", 32'(sum), 32'h5555);
      checkOutput("backpressure cout", 32'(cout), 32'd0);
      checkOutput("backpressure ovf", 32'(ovf), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("backpressure released", 32'(in_ready), 32'd1);

    // Reset after two RUN cycles aborts the add at once.
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset sum", 32'(sum), 32'd0);
    checkOutput("midreset cout", 32'(cout), 32'd0);
    checkOutput("midreset ovf", 32'(ovf), 32'd0);
    sawValid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      sawValid = sawValid | out_valid;
    end
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      sawValid = sawValid | out_valid;
    end
    checkOutput("midreset no out_valid pulse", 32'(sawValid), 32'd0);
    applyStimulus("after reset", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 0);

    // Back-to-back random adds with random consumer stalls.
    for (int i = 0; i < 50; i++) begin
      ra     = 16'($urandom);
      rb     = 16'($urandom);
      rc     = 1'($urandom_range(0, 1));
      stall  = int'($urandom_range(0, 3));
      full   = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      expOvf = (ra[15] == rb[15]) && (full[15] != ra[15]);
      applyStimulus($sformatf("rand%0d", i), ra, rb, rc, full[15:0], full[16], expOvf, stall);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
